fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: Reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ram_addr  output  32  fetch address to instruction RAM; always equals internal fetch PC (fpc).
REQ-004 SHALL have port: ram_data  input  32  instruction word at ram_addr, valid the same cycle (combinational RAM read).
REQ-005 SHALL have port: pop  input  1  IF/ID load enable; consumer takes head entry this cycle.
REQ-006 SHALL have port: flush  input  1  taken branch; discard queue and redirect fetch.
REQ-007 SHALL have port: target  input  32  branch target address, sampled when flush=1.
REQ-008 SHALL have port: out_valid  output  1  head entry present.
REQ-009 SHALL have port: out_instr  output  32  head instruction word.
REQ-010 SHALL have port: out_pc4  output  32  head instruction address + 4.
REQ-011 SHALL have port: count  output  3  occupied entries, 0..4.

Function
REQ-012 SHALL hold a 4-entry circular FIFO of {pc4[31:0], instr[31:0]} with 2-bit read/write pointers wrapping 3->0.
REQ-013 SHALL compute push = !flush && (count<4 || (pop && out_valid)); on push store {fpc+4, ram_data} at write pointer and set fpc <= fpc+4.
REQ-014 SHALL perform a pop when pop=1 && out_valid=1 && flush=0: advance read pointer; pop with count=0 SHALL be ignored.
REQ-015 SHALL update count as count + push - pop; simultaneous push and pop when full SHALL leave count=4.
REQ-016 SHALL stall fetch when count=4 and no pop: fpc and queue contents unchanged.
REQ-017 SHALL give flush priority over push and pop: next cycle count=0, pointers=0, fpc={target[31:2],2'b00}; the ram_data present in the flush cycle SHALL be dropped.
REQ-018 SHALL drive out_valid=(count!=0), out_instr/out_pc4 from head entry when valid, and 0 when out_valid=0.
REQ-019 SHALL wrap fpc and pc4 arithmetic modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-020 SHALL have 1-cycle fetch-to-output latency: word fetched at edge N is visible at head after edge N when queue was empty.

Reset
REQ-021 SHALL, while Reset=0, asynchronously force fpc=0, count=0, both pointers=0, out_valid=0, out_instr=0, out_pc4=0, ram_addr=0.
REQ-022 SHALL begin fetching from address 0 on the first rising edge after Reset deasserts; Reset asserted mid-operation SHALL discard all entries regardless of pop/flush.
REQ-023 SHALL not require FIFO storage array to be reset; contents are unobservable while count=0.

Configuration
REQ-024 SHALL, when FETCH_QUEUE_BYPASS_EN is defined, when count=0 and flush=0, drive out_valid=1, out_instr=ram_data, out_pc4=fpc+4 combinationally (0-cycle latency); if pop=1 that cycle the word is consumed, not stored, and fpc advances.
REQ-025 SHALL, when FETCH_QUEUE_BYPASS_EN is undefined, follow REQ-018/REQ-020 exactly (no combinational path from ram_data to outputs).

Verification
REQ-026 Bench SHALL cover: reset release, RAM[0..3]=0xE0825005,0xE3A01001,0xE3A02002,0xE3A03003, pop=1 every cycle -> out_instr sequence 0xE0825005.. with out_pc4=4,8,12,16, count stays 1 (0 with bypass).
REQ-027 Bench SHALL cover: pop=0 for 6 cycles after reset -> count 1,2,3,4,4,4; ram_addr stops at 16; out_instr stays 0xE0825005.
REQ-028 Bench SHALL cover: queue full, pop=1 one cycle -> count stays 4, head becomes word@4, ram_addr 16->20.
REQ-029 Bench SHALL cover: count=3, flush=1 with target=0x00000042 and pop=1 -> next cycle count=0, out_valid=0, ram_addr=0x40; following cycle head out_pc4=0x44.
REQ-030 Bench SHALL cover: Reset pulsed low mid-stream with count=2 -> immediately out_valid=0, count=0, ram_addr=0; fetch restarts at 0.
REQ-031 Bench SHALL cover: flush target=0xFFFFFFFC, pop=0 -> entries with out_pc4=0x00000000 then fpc wraps to 0x00000004.

Source files
------------

// File: rtl/fetch_queue.sv
// Four-entry instruction fetch queue between a combinational instruction RAM and IF/ID.
// Define FETCH_QUEUE_BYPASS_EN to present the RAM word directly when the queue is empty.
module fetch_queue (
    input  logic        clk,
    input  logic        Reset,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_data,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] target,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    output logic [2:0]  count
);

    localparam int unsigned Depth = 4;

    logic [31:0] r_fpc;
    logic [2:0]  r_count;
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [31:0] r_instr_mem [Depth];
    logic [31:0] r_pc4_mem   [Depth];

    logic [31:0] w_fpc4;
    logic        w_q_valid;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_byp;
    logic        w_byp_take;
    logic        w_fetch_adv;
    logic [2:0]  w_count_nxt;
    logic        w_unused_target;

    // Branch targets are word aligned; the low bits are dropped on redirect.
    assign w_unused_target = ^target[1:0];

    assign w_fpc4    = r_fpc + 32'd4;
    assign w_q_valid = (r_count != 3'd0);
    assign w_full    = (r_count == 3'd4);
    assign w_pop     = pop && w_q_valid && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards the RAM word; gated by Reset so outputs stay quiet during reset.
    assign w_byp      = Reset && !w_q_valid && !flush;
    assign w_byp_take = w_byp && pop;
`else
    assign w_byp      = 1'b0;
    assign w_byp_take = 1'b0;
`endif

    assign w_push      = !flush && !w_byp_take && (!w_full || w_pop);
    assign w_fetch_adv = w_push || w_byp_take;
    assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};

    // Storage array carries no reset; entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= ram_data;
            r_pc4_mem[r_wr_ptr]   <= w_fpc4;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_fpc    <= 32'd0;
            r_count  <= 3'd0;
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
        end else if (flush) begin
            r_fpc    <= {target[31:2], 2'b00};
            r_count  <= 3'd0;
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
        end else begin
            if (w_fetch_adv) begin
                r_fpc <= w_fpc4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_instr = 32'd0;
        out_pc4   = 32'd0;
        if (w_q_valid) begin
            out_valid = 1'b1;
            out_instr = r_instr_mem[r_rd_ptr];
            out_pc4   = r_pc4_mem[r_rd_ptr];
        end else if (w_byp) begin
            out_valid = 1'b1;
            out_instr = ram_data;
            out_pc4   = w_fpc4;
        end
    end

    assign ram_addr = r_fpc;
    assign count    = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, no bypass) with a combinational RAM model.
module tb_fetch_queue;

    logic        clk;
    logic        Reset;
    logic [31:0] ram_addr;
    logic [31:0] ram_data;
    logic        pop;
    logic        flush;
    logic [31:0] target;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [2:0]  count;

    int n_tests;
    int n_fail;

    fetch_queue dut (
        .clk       (clk),
        .Reset     (Reset),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .pop       (pop),
        .flush     (flush),
        .target    (target),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        case (addr)
            32'h0:   ram_word = 32'hE0825005;
            32'h4:   ram_word = 32'hE3A01001;
            32'h8:   ram_word = 32'hE3A02002;
            32'hC:   ram_word = 32'hE3A03003;
            default: ram_word = {8'hA5, addr[23:0]};
        endcase
    endfunction

    always_comb ram_data = ram_word(ram_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [2:0] exp_cnt,
                              input logic [31:0] exp_addr, input logic [31:0] exp_instr,
                              input logic [31:0] exp_pc4);
        check_eq({tag, ".count"}, {29'd0, count}, {29'd0, exp_cnt});
        check_eq({tag, ".valid"}, {31'd0, out_valid}, {31'd0, (exp_cnt != 3'd0)});
        check_eq({tag, ".addr"},  ram_addr,  exp_addr);
        check_eq({tag, ".instr"}, out_instr, exp_instr);
        check_eq({tag, ".pc4"},   out_pc4,   exp_pc4);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Reset   = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        target  = 32'd0;

        // Held in reset
        tick();
        tick();
        check_head("rst", 3'd0, 32'd0, 32'd0, 32'd0);

        // Fill with no pops: count saturates at 4 and fetch stalls at 16
        Reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_head($sformatf("fill%0d", i), (i < 4) ? 3'(i) : 3'd4,
                       (i < 4) ? 32'(4 * i) : 32'd16, 32'hE0825005, 32'd4);
        end

        // Full with one pop: push and pop together keep count at 4
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check_head("fullpop", 3'd4, 32'd20, 32'hE3A01001, 32'd8);
        tick();
        check_head("fullstall", 3'd4, 32'd20, 32'hE3A01001, 32'd8);

        // Redirect to 0, build up two entries, then reset mid-cycle
        flush  = 1'b1;
        target = 32'd0;
        tick();
        flush = 1'b0;
        check_head("flush0", 3'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        check_head("pre_rst", 3'd2, 32'd8, 32'hE0825005, 32'd4);
        #2;
        Reset = 1'b0;
        #1;
        check_head("async_rst", 3'd0, 32'd0, 32'd0, 32'd0);

        // Streaming: pop every cycle, pop on empty ignored
        pop = 1'b1;
        @(negedge clk);
        Reset = 1'b1;
        tick();
        check_head("stream1", 3'd1, 32'd4, 32'hE0825005, 32'd4);
        tick();
        check_head("stream2", 3'd1, 32'd8, 32'hE3A01001, 32'd8);
        tick();
        check_head("stream3", 3'd1, 32'd12, 32'hE3A02002, 32'd12);
        tick();
        check_head("stream4", 3'd1, 32'd16, 32'hE3A03003, 32'd16);

        // Build to count 3, then flush with pop asserted
        pop = 1'b0;
        tick();
        tick();
        check_head("cnt3", 3'd3, 32'd24, 32'hE3A03003, 32'd16);
        flush  = 1'b1;
        pop    = 1'b1;
        target = 32'h00000042;
        tick();
        flush = 1'b0;
        pop   = 1'b0;
        check_head("flush42", 3'd0, 32'h40, 32'd0, 32'd0);
        tick();
        check_head("after42", 3'd1, 32'h44, 32'hA5000040, 32'h44);

        // Wrap at top of address space
        flush  = 1'b1;
        target = 32'hFFFFFFFC;
        tick();
        flush = 1'b0;
        check_head("flushtop", 3'd0, 32'hFFFFFFFC, 32'd0, 32'd0);
        tick();
        check_head("wrap1", 3'd1, 32'h0, 32'hA5FFFFFC, 32'h0);
        tick();
        check_head("wrap2", 3'd2, 32'h4, 32'hA5FFFFFC, 32'h0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check_head("wrap3", 3'd2, 32'h8, 32'hE0825005, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
